// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU issue stage.
//   - ALU_XLEN    : default datapath width
//   - ALU_*       : 3-bit ALU op codes understood by the execute stage
//   - OPC_*       : RV32I major opcodes handled by this stage
//   - F3_* / F7_* : funct3 / funct7 field values used during decode
package alu_pkg;

    localparam int ALU_XLEN = 32;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_NOR = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SLL = 3'd7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: register file with two asynchronous read ports and one
// synchronous write port. Entry 0 is hardwired to zero and never written.
// A read of the address being written in the same cycle returns the write
// data, so a consumer sees a writeback without an extra cycle.
// Ports:
//   clk, rst               : clock, async active-high reset (clears all entries)
//   rd_addr_a / rd_data_a  : read port A
//   rd_addr_b / rd_data_b  : read port B
//   wr_en, wr_addr, wr_data: write port
module reg_file_2r1w #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [XLEN-1:0]   rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [XLEN-1:0]   rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data
);

    logic [XLEN-1:0] regs_r [NUM_REGS];
    logic            wr_ok_s;

    assign wr_ok_s = wr_en && (wr_addr != {ADDR_W{1'b0}});

    // Storage: cleared on reset, written on a qualified write strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // Read port A with x0 forcing and write bypass.
    always_comb begin
        rd_data_a = {XLEN{1'b0}};
        if (rd_addr_a == {ADDR_W{1'b0}}) begin
            rd_data_a = {XLEN{1'b0}};
        end else if (wr_ok_s && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end else begin
            rd_data_a = regs_r[rd_addr_a];
        end
    end

    // Read port B with x0 forcing and write bypass.
    always_comb begin
        rd_data_b = {XLEN{1'b0}};
        if (rd_addr_b == {ADDR_W{1'b0}}) begin
            rd_data_b = {XLEN{1'b0}};
        end else if (wr_ok_s && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end else begin
            rd_data_b = regs_r[rd_addr_b];
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode / operand-fetch stage in front of the 32-bit ALU.
// Decodes one RV32I integer ALU instruction per handshake into a 3-bit ALU
// op, reads operands from the register file, and holds the result in a
// registered valid/ready slot for the execute stage. A scoreboard of
// outstanding destination writes stalls RAW and WAW hazards until the
// matching writeback arrives.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   instr_valid/instr_ready   : upstream handshake, instr = instruction word
//   ex_valid/ex_ready         : downstream handshake
//   ex_in0, ex_in1, ex_op     : ALU operands and op code
//   ex_rd, ex_illegal         : destination register, not-executable flag
//   wb_en, wb_rd, wb_data     : writeback port (register file + scoreboard)
import alu_pkg::*;

module alu_issue_stage #(
    parameter int XLEN     = ALU_XLEN,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_in0,
    output logic [XLEN-1:0] ex_in1,
    output logic [2:0]      ex_op,
    output logic [4:0]      ex_rd,
    output logic            ex_illegal,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    // Instruction fields
    logic [6:0] opcode_s;
    logic [4:0] rd_s;
    logic [2:0] funct3_s;
    logic [4:0] rs1_s;
    logic [4:0] rs2_s;
    logic [6:0] funct7_s;

    assign opcode_s = instr[6:0];
    assign rd_s     = instr[11:7];
    assign funct3_s = instr[14:12];
    assign rs1_s    = instr[19:15];
    assign rs2_s    = instr[24:20];
    assign funct7_s = instr[31:25];

    logic            dec_legal_s;
    logic [2:0]      dec_op_s;
    logic            dec_shift_s;
    logic            dec_rtype_s;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] rs1_data_s;
    logic [XLEN-1:0] rs2_data_s;
    logic [XLEN-1:0] in0_s;
    logic [XLEN-1:0] in1_s;

    logic [NUM_REGS-1:0] sb_r;
    logic [NUM_REGS-1:0] sb_clr_s;
    logic [NUM_REGS-1:0] sb_set_s;
    logic [NUM_REGS-1:0] pend_s;
    logic                stall_s;
    logic                accept_s;

    assign imm_s       = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign dec_rtype_s = dec_legal_s && (opcode_s == OPC_OP);

    // Decode opcode/funct3/funct7 into an ALU op and a legality flag.
    always_comb begin
        dec_legal_s = 1'b0;
        dec_op_s    = ALU_AND;
        dec_shift_s = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                case (funct3_s)
                    F3_ADD: begin
                        if (funct7_s == F7_BASE) begin
                            dec_legal_s = 1'b1;
                            dec_op_s    = ALU_ADD;
                        end else if (funct7_s == F7_ALT) begin
                            dec_legal_s = 1'b1;
                            dec_op_s    = ALU_SUB;
                        end else begin
                            dec_legal_s = 1'b0;
                        end
                    end
                    F3_AND: begin
                        dec_legal_s = (funct7_s == F7_BASE);
                        dec_op_s    = ALU_AND;
                    end
                    F3_OR: begin
                        dec_legal_s = (funct7_s == F7_BASE);
                        dec_op_s    = ALU_OR;
                    end
                    F3_SLT: begin
                        dec_legal_s = (funct7_s == F7_BASE);
                        dec_op_s    = ALU_SLT;
                    end
                    default: dec_legal_s = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                case (funct3_s)
                    F3_ADD: begin
                        dec_legal_s = 1'b1;
                        dec_op_s    = ALU_ADD;
                    end
                    F3_AND: begin
                        dec_legal_s = 1'b1;
                        dec_op_s    = ALU_AND;
                    end
                    F3_OR: begin
                        dec_legal_s = 1'b1;
                        dec_op_s    = ALU_OR;
                    end
                    F3_SLT: begin
                        dec_legal_s = 1'b1;
                        dec_op_s    = ALU_SLT;
                    end
                    // The ALU only shifts by one, so any other shamt is illegal.
                    F3_SLL: begin
                        dec_legal_s = (funct7_s == F7_BASE) && (rs2_s == 5'd1);
                        dec_op_s    = ALU_SLL;
                        dec_shift_s = 1'b1;
                    end
                    F3_SRL: begin
                        dec_legal_s = (funct7_s == F7_BASE) && (rs2_s == 5'd1);
                        dec_op_s    = ALU_SRL;
                        dec_shift_s = 1'b1;
                    end
                    default: dec_legal_s = 1'b0;
                endcase
            end
            default: dec_legal_s = 1'b0;
        endcase
    end

    reg_file_2r1w #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (5)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rs1_s),
        .rd_data_a (rs1_data_s),
        .rd_addr_b (rs2_s),
        .rd_data_b (rs2_data_s),
        .wr_en     (wb_en),
        .wr_addr   (wb_rd),
        .wr_data   (wb_data)
    );

    // Operand selection; illegal instructions carry zero operands.
    always_comb begin
        in0_s = {XLEN{1'b0}};
        in1_s = {XLEN{1'b0}};
        if (!dec_legal_s) begin
            in0_s = {XLEN{1'b0}};
            in1_s = {XLEN{1'b0}};
        end else if (dec_rtype_s) begin
            in0_s = rs1_data_s;
            in1_s = rs2_data_s;
        end else if (dec_shift_s) begin
            in0_s = rs1_data_s;
            in1_s = {XLEN{1'b0}};
        end else begin
            in0_s = rs1_data_s;
            in1_s = imm_s;
        end
    end

    // Scoreboard clear/set masks; a bit being cleared this cycle is already free.
    always_comb begin
        sb_clr_s = {NUM_REGS{1'b0}};
        sb_set_s = {NUM_REGS{1'b0}};
        if (wb_en) begin
            sb_clr_s[wb_rd] = 1'b1;
        end else begin
            sb_clr_s = {NUM_REGS{1'b0}};
        end
        if (accept_s && dec_legal_s && (rd_s != 5'd0)) begin
            sb_set_s[rd_s] = 1'b1;
        end else begin
            sb_set_s = {NUM_REGS{1'b0}};
        end
    end

    assign pend_s  = sb_r & ~sb_clr_s;
    assign stall_s = dec_legal_s &&
                     (pend_s[rs1_s] || (dec_rtype_s && pend_s[rs2_s]) || pend_s[rd_s]);

    assign instr_ready = (!ex_valid || ex_ready) && !stall_s;
    assign accept_s    = instr_valid && instr_ready;

    // Scoreboard register; set takes priority over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_r <= {NUM_REGS{1'b0}};
        end else begin
            sb_r <= (sb_r & ~sb_clr_s) | sb_set_s;
        end
    end

    // Execute-side output slot: load on accept, drop valid when consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_in0     <= {XLEN{1'b0}};
            ex_in1     <= {XLEN{1'b0}};
            ex_op      <= 3'd0;
            ex_rd      <= 5'd0;
            ex_illegal <= 1'b0;
        end else if (accept_s) begin
            ex_valid   <= 1'b1;
            ex_in0     <= in0_s;
            ex_in1     <= in1_s;
            ex_op      <= dec_legal_s ? dec_op_s : ALU_AND;
            ex_rd      <= rd_s;
            ex_illegal <= !dec_legal_s;
        end else if (ex_ready) begin
            ex_valid   <= 1'b0;
        end
    end

endmodule
